// File: rtl/cpu_out_logger.sv
// cpu_out_logger: captures every change on the CPU output bus into a
// first-word-fall-through FIFO and drains it over a valid/ready stream.
// Logging stops when the CPU halts; done is raised once the log is empty.
module cpu_out_logger #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cpu_out,
  input  logic              cpu_halt,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              done
);

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    FINISHED
  } state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [DATA_W-1:0]   prev_out;

  logic capture;
  logic full;
  logic push;
  logic pop;

  // A capture is any change of the bus while still running; fullness is
  // judged on the occupancy before this edge's pop.
  assign capture = (state == RUN) && (cpu_out != prev_out);
  assign full    = (count == FULL_COUNT);
  assign push    = capture && !full;
  assign pop     = m_valid && m_ready;

  // Head of the FIFO falls through; zero when empty so reset shows m_data=0.
  assign m_valid = (count != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;
  assign m_last  = m_valid && (state != RUN) && (count == ONE);

  // Storage write port.
  // NOTE: the data array has no reset; the pointers and count define which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cpu_out;
    end
  end

  // Pointers, occupancy, sticky flags and the run/halt/finish sequence.
  // NOTE: every register here uses non-blocking assignment so all of them
  // see the pre-edge values of count/state, matching the combinational
  // push/pop decisions above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      prev_out <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (state == RUN) begin
        prev_out <= cpu_out;
      end

      if (capture && full) begin
        overflow <= 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase

      case (state)
        RUN: begin
          if (cpu_halt) begin
            state <= HALTED;
          end
        end
        HALTED: begin
          // Empty with nothing in flight, or the last entry leaves now.
          if ((count == '0) || (pop && (count == ONE))) begin
            state <= FINISHED;
            done  <= 1'b1;
          end
        end
        FINISHED: begin
          done <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_out_logger.sv
// Bench for cpu_out_logger: directed stimulus pushes expected beats into a
// scoreboard queue; a monitor pops and compares on every accepted beat.
module tb_cpu_out_logger;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] cpu_out;
  logic              cpu_halt;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              done;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sb [$];

  cpu_out_logger #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_out  (cpu_out),
    .cpu_halt (cpu_halt),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .count    (count),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [DATA_W-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    sb.push_back(b);
  endtask

  // Monitor: every beat the sink accepts must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", {24'h0, m_data}, 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = sb.pop_front();
        check("beat_data", {24'h0, m_data}, {24'h0, b.data});
        check("beat_last", {31'h0, m_last}, {31'h0, b.last});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] t2 [7];
    logic [DATA_W-1:0] prev;
    logic              chg;
    t2 = '{8'h42, 8'h42, 8'h42, 8'h43, 8'h43, 8'h00, 8'h07};

    // T1: reset with a nonzero bus value
    rst = 1'b1; cpu_out = 8'h42; cpu_halt = 1'b0; m_ready = 1'b1;
    step(); step();
    check("rst_m_valid",  {31'h0, m_valid},  32'h0);
    check("rst_count",    {27'h0, count},    32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_done",     {31'h0, done},     32'h0);
    check("rst_m_data",   {24'h0, m_data},   32'h0);
    check("rst_m_last",   {31'h0, m_last},   32'h0);
    rst = 1'b0;

    // T2: one beat per change, visible the cycle after the change
    prev = 8'h00;
    foreach (t2[i]) begin
      cpu_out = t2[i];
      chg = (t2[i] != prev);
      if (chg) expect_beat(t2[i], 1'b0);
      step();
      check("t2_count",   {27'h0, count},   {31'h0, chg});
      check("t2_m_valid", {31'h0, m_valid}, {31'h0, chg});
      prev = t2[i];
    end
    step();
    check("t2_drained", {27'h0, count}, 32'h0);

    // T3: fill with sink stalled, 17th distinct value overflows
    m_ready = 1'b0;
    for (int v = 1; v <= 16; v++) begin
      cpu_out = DATA_W'(v);
      expect_beat(DATA_W'(v), 1'b0);
      step();
    end
    check("t3_count_full",   {27'h0, count},    32'd16);
    check("t3_no_overflow",  {31'h0, overflow}, 32'h0);
    cpu_out = 8'h11;
    step();
    check("t3_count_hold",   {27'h0, count},    32'd16);
    check("t3_overflow",     {31'h0, overflow}, 32'h1);

    // T4: full plus pop on the same edge as a new value; the value is dropped
    cpu_out = 8'h99; m_ready = 1'b1;
    step();
    check("t4_count",    {27'h0, count},    32'd15);
    check("t4_overflow", {31'h0, overflow}, 32'h1);
    for (int i = 0; i < 15; i++) step();
    check("t4_drained", {27'h0, count}, 32'h0);

    // T5: halt coincident with a change
    cpu_out = 8'h10;
    expect_beat(8'h10, 1'b0);
    step(); step();
    check("t5_pre_count", {27'h0, count}, 32'h0);
    cpu_out = 8'h55; cpu_halt = 1'b1; m_ready = 1'b0;
    expect_beat(8'h55, 1'b1);
    step();
    check("t5_count_55",  {27'h0, count},  32'h1);
    check("t5_m_last",    {31'h0, m_last}, 32'h1);
    check("t5_m_data",    {24'h0, m_data}, 32'h55);
    check("t5_done_wait", {31'h0, done},   32'h0);
    cpu_out = 8'h66;
    step();
    check("t5_66_ignored", {27'h0, count}, 32'h1);
    check("t5_stable",     {24'h0, m_data}, 32'h55);
    m_ready = 1'b1;
    step();
    check("t5_done",       {31'h0, done},  32'h1);
    check("t5_count_zero", {27'h0, count}, 32'h0);
    cpu_halt = 1'b0; cpu_out = 8'h77;
    step();
    check("t5_done_sticky", {31'h0, done},  32'h1);
    check("t5_no_capture",  {27'h0, count}, 32'h0);

    // T6: reset in the middle of a drain
    rst = 1'b1; sb.delete();
    step();
    rst = 1'b0; m_ready = 1'b0;
    cpu_out = 8'h00;
    step();
    for (int v = 8'h21; v <= 8'h25; v++) begin
      cpu_out = DATA_W'(v);
      expect_beat(DATA_W'(v), 1'b0);
      step();
    end
    check("t6_count5", {27'h0, count}, 32'd5);
    m_ready = 1'b1; step();
    m_ready = 1'b0; step();
    m_ready = 1'b1; step();
    check("t6_count3", {27'h0, count}, 32'd3);
    rst = 1'b1; sb.delete();
    step();
    check("t6_count",   {27'h0, count},   32'h0);
    check("t6_m_valid", {31'h0, m_valid}, 32'h0);
    check("t6_done",    {31'h0, done},    32'h0);
    rst = 1'b0;
    // prev_out cleared, so the held 0x25 is logged again
    expect_beat(8'h25, 1'b0);
    step();
    check("t6_resume_valid", {31'h0, m_valid}, 32'h1);
    check("t6_resume_count", {27'h0, count},   32'h1);
    step();
    check("t6_resume_drain", {27'h0, count}, 32'h0);
    cpu_halt = 1'b1;
    step();
    check("t6_halt_not_done", {31'h0, done}, 32'h0);
    step();
    check("t6_halt_done",     {31'h0, done}, 32'h1);

    step();
    check("sb_empty", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
